// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for the RV64 datapath. Steps every
//               instruction through fetch/decode/execute/memory/writeback,
//               drives all datapath enables and mux selects, handshakes with
//               the instruction/data memories under a bounded wait, and
//               counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,  // max cycles a memory req waits for ready (1..255)
  parameter int CNT_W   = 64    // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic [6:0]       opcode,      // IR[6:0]
  input  logic [2:0]       funct3,      // IR[14:12]
  input  logic             zero,        // ALU zero flag
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // IR is stable from DECODE onward, so the opcode class can be decoded live.
  logic is_r, is_i, is_load, is_store, is_branch, is_ls, timeout_hit;

  assign is_r        = (opcode == OP_R);
  assign is_i        = (opcode == OP_I);
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign is_branch   = (opcode == OP_BRANCH);
  assign is_ls       = is_load | is_store;
  assign timeout_hit = (wait_q == TIMEOUT_W);

  assign instret = instret_q;

  // Next-state, wait counter, retire counter and Mealy output decode.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    instret_d  = instret_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        wait_d  = 8'd0;
      end

      ST_FETCH: begin
        if (imem_ready) begin
          // Ready beats a simultaneous timeout.
          imem_req = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout_hit) begin
          // Give up without touching IR/PC so the same PC is re-fetched.
          bus_error = 1'b1;
          wait_d    = 8'd0;
          state_d   = ST_FETCH;
        end else begin
          imem_req = 1'b1;
          wait_d   = wait_q + 8'd1;
        end
      end

      ST_DECODE: begin
        if (is_r || is_i || is_ls) begin
          state_d = ST_EXEC;
        end else if (is_branch) begin
          state_d = ST_BRANCH;
        end else begin
          // PC was already advanced during fetch; just move on.
          illegal = 1'b1;
          wait_d  = 8'd0;
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        if (is_ls) begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
          wait_d  = 8'd0;
          state_d = ST_MEM;
        end else begin
          alu_src = is_i;
          alu_op  = ALU_FUNCT;
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        if (dmem_ready) begin
          dmem_req  = 1'b1;
          mem_write = is_store;
          if (is_store) begin
            instret_d = instret_q + CNT_W'(1);
            wait_d    = 8'd0;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          bus_error = 1'b1;
          wait_d    = 8'd0;
          state_d   = ST_FETCH;
        end else begin
          dmem_req  = 1'b1;
          mem_write = is_store;
          wait_d    = wait_q + 8'd1;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        instret_d  = instret_q + CNT_W'(1);
        wait_d     = 8'd0;
        state_d    = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src = 1'b0;
        alu_op  = ALU_SUB;
        wait_d  = 8'd0;
        state_d = ST_FETCH;
        case (funct3)
          3'b000: begin
            pc_write  = zero;
            pc_src    = zero;
            instret_d = instret_q + CNT_W'(1);
          end
          3'b001: begin
            pc_write  = ~zero;
            pc_src    = ~zero;
            instret_d = instret_q + CNT_W'(1);
          end
          default: begin
            illegal = 1'b1;
          end
        endcase
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RST;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Directed scenarios
//               followed by randomized instructions, each judged against an
//               instruction-level model (latency, enable counts, retire).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             mem_write;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_to_reg;
  logic             illegal;
  logic             bus_error;
  logic [CNT_W-1:0] instret;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] model_instret;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .bus_error  (bus_error),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // All single-bit/control outputs packed together for all-zero checks.
  wire [13:0] all_outs = {imem_req, dmem_req, mem_write, pc_write, pc_src, ir_write,
                          reg_write, alu_src, alu_op, mem_to_reg, illegal, bus_error};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one instruction from its first fetch cycle. The model derives the
  // cycle count and the number of cycles each enable should be seen from the
  // instruction class and the memory delays.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int di, input int dd);
    bit is_r, is_i, is_l, is_s, is_b, legal_op, br_ok, taken, retire, mem;
    int lat;
    logic [2:0] exp_alu, seen_alu;
    int n_imem, n_dmem, n_mw, n_ir, n_pcw, n_pcs, n_rw, n_m2r, n_ill, n_be, n_excl;
    is_r = (op == OP_R);
    is_i = (op == OP_I);
    is_l = (op == OP_LOAD);
    is_s = (op == OP_STORE);
    is_b = (op == OP_BRANCH);
    legal_op = is_r | is_i | is_l | is_s | is_b;
    br_ok    = is_b && (f3 == 3'b000 || f3 == 3'b001);
    taken    = br_ok && ((f3 == 3'b000) ? z : !z);
    retire   = is_r | is_i | is_l | is_s | br_ok;
    mem      = is_l | is_s;
    if (!legal_op)         lat = 2;
    else if (is_b)         lat = 3;
    else if (is_l)         lat = 5;
    else                   lat = 4;
    lat = lat + di + (mem ? dd : 0);
    if (is_r)      exp_alu = 3'b010;
    else if (is_i) exp_alu = 3'b110;
    else if (mem)  exp_alu = 3'b100;
    else           exp_alu = 3'b001;
    seen_alu = 3'bxxx;
    n_imem = 0; n_dmem = 0; n_mw = 0; n_ir = 0; n_pcw = 0; n_pcs = 0;
    n_rw = 0; n_m2r = 0; n_ill = 0; n_be = 0; n_excl = 0;

    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        opcode = op;
        funct3 = f3;
        zero   = z;
      end
      imem_ready = (k == di);
      dmem_ready = mem && (k == di + 3 + dd);
      #1;
      if (k == 0) check("instret_at_start", 64'(instret), 64'(model_instret));
      n_imem += int'(imem_req);
      n_dmem += int'(dmem_req);
      n_mw   += int'(mem_write);
      n_ir   += int'(ir_write);
      n_pcw  += int'(pc_write);
      n_pcs  += int'(pc_src);
      n_rw   += int'(reg_write);
      n_m2r  += int'(reg_write && mem_to_reg);
      n_ill  += int'(illegal);
      n_be   += int'(bus_error);
      n_excl += int'((imem_req && dmem_req) || (pc_write && reg_write));
      if (legal_op && k == di + 2) seen_alu = {alu_src, alu_op};
    end

    check("imem_req_cycles",  64'(n_imem), 64'(di + 1));
    check("ir_write_cycles",  64'(n_ir),   64'(1));
    check("pc_write_cycles",  64'(n_pcw),  64'(taken ? 2 : 1));
    check("pc_src_cycles",    64'(n_pcs),  64'(taken ? 1 : 0));
    check("dmem_req_cycles",  64'(n_dmem), 64'(mem ? dd + 1 : 0));
    check("mem_write_cycles", 64'(n_mw),   64'(is_s ? dd + 1 : 0));
    check("reg_write_cycles", 64'(n_rw),   64'((is_r || is_i || is_l) ? 1 : 0));
    check("mem_to_reg_wb",    64'(n_m2r),  64'(is_l ? 1 : 0));
    check("illegal_pulses",   64'(n_ill),  64'(retire ? 0 : 1));
    check("bus_error_pulses", 64'(n_be),   64'(0));
    check("exclusive_enables", 64'(n_excl), 64'(0));
    if (legal_op) check("alu_ctrl", 64'(seen_alu), 64'(exp_alu));
    if (retire) model_instret = model_instret + 1'b1;
  endtask

  initial begin
    int n_req, n_be, n_ir, n_pcw;
    int sel, di, dd;
    logic [6:0] rop;
    logic [2:0] rf3;

    reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    model_instret = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'(0));
    check("reset_instret", 64'(instret), 64'(0));

    // Release and walk a load into MEM, then pull reset with dmem_ready high.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_state_outputs", 64'(all_outs), 64'(0));
    opcode = OP_LOAD; funct3 = 3'b011;
    @(negedge clk); imem_ready = 1'b1; #1;
    check("ld_fetch_ir_write", 64'(ir_write), 64'(1));
    @(negedge clk); imem_ready = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("ld_mem_req", 64'({dmem_req, mem_write}), 64'(2'b10));
    #1;
    reset = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check("reset_mid_mem_outputs", 64'(all_outs), 64'(0));
    @(posedge clk); #1;
    check("reset_held_outputs", 64'(all_outs), 64'(0));
    check("reset_held_instret", 64'(instret), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    dmem_ready = 1'b0;
    #1;
    check("rst_after_release", 64'(all_outs), 64'(0));

    // Directed instructions.
    run_instr(OP_R,      3'b000, 1'b0, 0, 0);   // add, immediate readys
    run_instr(OP_LOAD,   3'b011, 1'b0, 0, 3);   // ld, dmem_ready 3 cycles late
    run_instr(OP_STORE,  3'b011, 1'b0, 1, 2);   // sd with waits
    run_instr(OP_I,      3'b000, 1'b0, 2, 0);   // addi
    run_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);   // beq taken
    run_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0);   // bne not taken
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);  // unsupported opcode
    run_instr(OP_BRANCH, 3'b010, 1'b1, 0, 0);   // bad branch funct3

    // Fetch timeout: imem_ready never arrives.
    n_req = 0; n_be = 0; n_ir = 0; n_pcw = 0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == 0) begin opcode = OP_R; funct3 = 3'b000; zero = 1'b0; end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      n_req += int'(imem_req);
      n_be  += int'(bus_error);
      n_ir  += int'(ir_write);
      n_pcw += int'(pc_write);
    end
    check("timeout_req_cycles", 64'(n_req), 64'(TIMEOUT));
    check("timeout_bus_error",  64'(n_be),  64'(1));
    check("timeout_no_ir_write", 64'(n_ir), 64'(0));
    check("timeout_no_pc_write", 64'(n_pcw), 64'(0));

    // Refetch with ready arriving exactly as the counter reaches TIMEOUT.
    run_instr(OP_R, 3'b000, 1'b0, TIMEOUT, 0);

    // Randomized instruction stream (long enough to wrap instret).
    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 7));
      di  = int'($urandom_range(0, TIMEOUT - 1));
      dd  = int'($urandom_range(0, TIMEOUT - 1));
      rf3 = 3'($urandom);
      case (sel)
        0: rop = OP_R;
        1: rop = OP_I;
        2: rop = OP_LOAD;
        3: rop = OP_STORE;
        4: begin rop = OP_BRANCH; rf3 = 3'b000; end
        5: begin rop = OP_BRANCH; rf3 = 3'b001; end
        6: begin rop = OP_BRANCH; rf3 = 3'($urandom_range(2, 7)); end
        default: begin
          rop = 7'($urandom);
          if (rop == OP_R || rop == OP_I || rop == OP_LOAD ||
              rop == OP_STORE || rop == OP_BRANCH) rop = 7'b0000000;
        end
      endcase
      run_instr(rop, rf3, 1'($urandom), di, dd);
    end

    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    check("final_instret", 64'(instret), 64'(model_instret));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV64 datapath: register file, ALU, immediate generator, PC/IR registers, instruction and data memories.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
- Handshakes with instruction and data memories over req/ready, with a bounded-wait timeout.
- Counts retired instructions.

Parameters:
- TIMEOUT, 255: maximum cycles a memory req may wait for ready before bus_error (1..255).
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- mem_write  out  1  with dmem_req: 1=store, 0=load
- pc_write  out  1  PC load enable
- pc_src  out  1  0=PC+4, 1=branch target (PC_old+imm)
- ir_write  out  1  IR and PC_old load enable
- reg_write  out  1  register file write enable
- alu_src  out  1  0=rs2, 1=immediate
- alu_op  out  2  00=add, 01=sub (compare), 10=funct-decoded
- mem_to_reg  out  1  writeback select: 1=load data
- illegal  out  1  one-cycle pulse: unsupported opcode
- bus_error  out  1  one-cycle pulse: memory timeout
- instret  out  CNT_W  retired instruction count

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, BRANCH.
- Reset low: state=RST, wait counter=0, instret=0.
- All outputs are decoded from the state register and inputs. In RST every output is 0. RST goes to FETCH unconditionally on the first edge after reset release.
- Reset low mid-instruction: immediate return to RST; no pending write completes.
- FETCH:
  - imem_req=1 until the cycle imem_ready=1.
  - In that cycle: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
- DECODE: no enables; one cycle.
  - 0110011 (R) or 0010011 (I-ALU), 0000011 (load), 0100011 (store): go to EXEC.
  - 1100011 (branch): go to BRANCH.
  - Any other opcode: illegal=1 for this cycle; go to FETCH (PC already advanced).
- EXEC:
  - R-type: alu_src=0, alu_op=10.
  - I-ALU: alu_src=1, alu_op=10.
  - Load/store: alu_src=1, alu_op=00.
  - Next state: MEM for load/store, WB otherwise.
- MEM:
  - dmem_req=1; mem_write=1 for store, 0 for load; held until dmem_ready.
  - Load on ready: go to WB.
  - Store on ready: instret+1; go to FETCH.
- WB:
  - reg_write=1; mem_to_reg=1 for load, 0 otherwise.
  - instret+1; go to FETCH.
- BRANCH: alu_src=0, alu_op=01.
  - funct3=000 (beq): taken=zero.
  - funct3=001 (bne): taken=!zero.
  - Any other funct3: illegal=1, not taken, no retire.
  - Taken: pc_write=1, pc_src=1. Not taken: no PC write (PC+4 already loaded in FETCH).
  - Valid branch: instret+1. Go to FETCH.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and increments each cycle req is held without ready.
  - When the counter reaches TIMEOUT with ready still low: deassert req, bus_error=1 for that cycle, no retire.
  - Next state is FETCH. A timeout in FETCH performs no ir_write/pc_write, so the same PC is re-fetched.
  - Ready in the same cycle the counter reaches TIMEOUT: ready wins, no bus_error.
- Latency in cycles, ready on first request cycle:
  - R/I-ALU: 4 (FETCH, DECODE, EXEC, WB).
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Each ready wait adds 1 cycle.
- instret wraps modulo 2^CNT_W.
- Never assert together: imem_req with dmem_req; pc_write with reg_write.

Test Plan:
- Reset low mid-MEM of a load, dmem_ready high while reset low -> all outputs 0, no reg_write; after release RST→FETCH, imem_req=1 next cycle; instret=0.
- add (0110011), both readys immediate -> states FETCH,DECODE,EXEC,WB; reg_write=1 only in cycle 4 with mem_to_reg=0; instret 0→1.
- ld (0000011), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, mem_write=0; WB with mem_to_reg=1; 8 cycles total; instret+1.
- beq with zero=1 -> BRANCH asserts pc_write=1, pc_src=1. bne with zero=1 -> no pc_write. Both retire in 3 cycles.
- opcode 1111111 -> illegal pulse in DECODE, back to FETCH, instret unchanged; branch funct3=010 -> illegal in BRANCH, no PC write.
- TIMEOUT=4, imem_ready held low -> bus_error pulses once, no ir_write, FETCH re-entered with counter cleared. Separate run: imem_ready high exactly on counter=4 -> normal fetch, no bus_error.
